// File: rtl/vm_input_cond.sv
// Input conditioning for the vending machine: synchronizes and debounces the raw buttons
// and switches, and produces press / auto-repeat pulses and a switch-change pulse.
module vm_input_cond #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 25000000,
    parameter int         REPEAT_RATE     = 5000000,
    parameter logic [3:0] REPEAT_MASK     = 4'b0011,
    parameter bit         BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic [9:0] sw_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [9:0] sw_stable,
    output logic       sw_changed
);

    localparam int NCH     = 14;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

    logic [3:0]     btn_in;
    logic [NCH-1:0] raw_in;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] stable;
    logic [NCH-1:0] stable_nxt;
    logic [3:0]     btn_rise;
    logic [3:0]     rpt_pulse;

    // Buttons are made active-high here; switches occupy the upper channels.
    assign btn_in = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign raw_in = {sw_raw, btn_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            mismatch;
        logic            accept;

        assign mismatch      = sync2[c] ^ stable[c];
        assign accept        = mismatch && (cnt == DB_LAST);
        assign stable_nxt[c] = accept ? sync2[c] : stable[c];

        // Any agreeing cycle restarts the count, so short bounces never accumulate.
        always_ff @(posedge clk) begin
            if (rst || !mismatch || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_rise = stable_nxt[3:0] & ~stable[3:0];

    for (genvar b = 0; b < 4; b++) begin : g_rpt
        rpt_state_t       state;
        rpt_state_t       state_nxt;
        logic [RPT_W-1:0] hold_cnt;
        logic [RPT_W-1:0] hold_cnt_nxt;
        logic             held;
        logic             pulse;

        // Decisions use the level being registered this edge, so a release cancels
        // a repeat that would otherwise land on the same edge.
        assign held = stable_nxt[b];

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
            end else begin
                state    <= state_nxt;
                hold_cnt <= hold_cnt_nxt;
            end
        end

        always_comb begin
            state_nxt    = state;
            hold_cnt_nxt = hold_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    hold_cnt_nxt = '0;
                    if (REPEAT_MASK[b] && btn_rise[b]) begin
                        state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!held) begin
                        state_nxt    = ST_IDLE;
                        hold_cnt_nxt = '0;
                    end else if (hold_cnt == DELAY_LAST) begin
                        state_nxt    = ST_REPEAT;
                        hold_cnt_nxt = '0;
                    end
                end
                ST_REPEAT: begin
                    if (!held) begin
                        state_nxt    = ST_IDLE;
                        hold_cnt_nxt = '0;
                    end else if (hold_cnt == RATE_LAST) begin
                        hold_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    hold_cnt_nxt = '0;
                end
            endcase
        end

        always_comb begin
            pulse = 1'b0;
            case (state)
                ST_DELAY:  pulse = held && (hold_cnt == DELAY_LAST);
                ST_REPEAT: pulse = held && (hold_cnt == RATE_LAST);
                default:   pulse = 1'b0;
            endcase
        end

        assign rpt_pulse[b] = pulse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable     <= '0;
            btn_press  <= '0;
            sw_changed <= 1'b0;
        end else begin
            stable     <= stable_nxt;
            btn_press  <= btn_rise | rpt_pulse;
            sw_changed <= |(stable_nxt[NCH-1:4] ^ stable[NCH-1:4]);
        end
    end

    assign btn_level = stable[3:0];
    assign sw_stable = stable[NCH-1:4];

endmodule
